// File: rtl/div_share_arbiter_if.sv
// Bundle of the requester-side and divider-side signals of div_share_arbiter.
// Ports:
//   req_valid/req_ready/req_dividend/req_divisor  : per-requester request channel
//   rsp_valid/rsp_ready/rsp_quotient             : per-requester response channel
//   div_valid_in/div_dividend/div_divisor        : start pulse and operands to the divider
//   div_valid_out/div_quotient                   : divider result
//   err_timeout                                  : sticky watchdog flag
// Modports: slave = the arbiter, master = requesters plus divider environment.
interface div_share_arbiter_if #(
   parameter int unsigned NUM_REQ        = 2,
   parameter int unsigned DIVIDEND_WIDTH = 16,
   parameter int unsigned DIVISOR_WIDTH  = 8
);
   logic [NUM_REQ-1:0]                req_valid;
   logic [NUM_REQ-1:0]                req_ready;
   logic [NUM_REQ*DIVIDEND_WIDTH-1:0] req_dividend;
   logic [NUM_REQ*DIVISOR_WIDTH-1:0]  req_divisor;
   logic [NUM_REQ-1:0]                rsp_valid;
   logic [NUM_REQ-1:0]                rsp_ready;
   logic [DIVIDEND_WIDTH-1:0]         rsp_quotient;
   logic                              div_valid_in;
   logic [DIVIDEND_WIDTH-1:0]         div_dividend;
   logic [DIVISOR_WIDTH-1:0]          div_divisor;
   logic                              div_valid_out;
   logic [DIVIDEND_WIDTH-1:0]         div_quotient;
   logic                              err_timeout;

   modport slave (
      input  req_valid, req_dividend, req_divisor, rsp_ready, div_valid_out, div_quotient,
      output req_ready, rsp_valid, rsp_quotient, div_valid_in, div_dividend, div_divisor,
             err_timeout
   );

   modport master (
      output req_valid, req_dividend, req_divisor, rsp_ready, div_valid_out, div_quotient,
      input  req_ready, rsp_valid, rsp_quotient, div_valid_in, div_dividend, div_divisor,
             err_timeout
   );
endinterface

// File: rtl/div_share_arbiter.sv
// Round-robin arbiter sharing one iterative unsigned divider among NUM_REQ
// requesters. One division is outstanding at a time; divide-by-zero is answered
// locally with an all-ones quotient without touching the divider.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : div_share_arbiter_if.slave (request, response and divider channels)
// Optional feature macro: DIV_ARB_TIMEOUT_EN enables a WAIT-state watchdog that
// answers with an all-ones quotient after TIMEOUT_CYCLES and sets err_timeout.
module div_share_arbiter #(
   parameter int unsigned NUM_REQ        = 2,
   parameter int unsigned DIVIDEND_WIDTH = 16,
   parameter int unsigned DIVISOR_WIDTH  = 8,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input logic                clock,
   input logic                reset,
   div_share_arbiter_if.slave bus
);
   localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned DW = DIVIDEND_WIDTH;
   localparam int unsigned VW = DIVISOR_WIDTH;

   // Elaboration-time guard on the supported configuration range.
   if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES == 0) begin : g_bad_param
      $error("div_share_arbiter: unsupported parameter value");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t        state_q, state_d;
   logic [GW-1:0] last_q, last_d;
   logic [GW-1:0] owner_q, owner_d;
   logic [DW-1:0] dvd_q, dvd_d;
   logic [VW-1:0] dvs_q, dvs_d;
   logic [DW-1:0] quo_q, quo_d;
   logic          accept;

`ifdef DIV_ARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wdog_q, wdog_d;
   logic          err_q, err_d;
`endif

   // Round-robin search starting just after the last granted requester.
   logic          grant_found;
   logic [GW-1:0] grant_idx;
   logic [GW-1:0] cand;
   logic [DW-1:0] grant_dvd;
   logic [VW-1:0] grant_dvs;

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = GW'((32'(last_q) + k) % NUM_REQ);
         if (!grant_found && bus.req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Operand slice of the granted requester.
   always_comb begin
      grant_dvd = '0;
      grant_dvs = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == GW'(i)) begin
            grant_dvd = bus.req_dividend[i*DW +: DW];
            grant_dvs = bus.req_divisor[i*VW +: VW];
         end
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      owner_d = owner_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      quo_d   = quo_q;
      accept  = 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
      wdog_d  = wdog_q;
      err_d   = err_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (grant_found) begin
               accept  = 1'b1;
               last_d  = grant_idx;
               owner_d = grant_idx;
               dvd_d   = grant_dvd;
               dvs_d   = grant_dvs;
               if (grant_dvs == '0) begin
                  quo_d   = '1;
                  state_d = RESP;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            state_d = WAIT;
`ifdef DIV_ARB_TIMEOUT_EN
            wdog_d  = '0;
`endif
         end
         WAIT: begin
            if (bus.div_valid_out) begin
               quo_d   = bus.div_quotient;
               state_d = RESP;
            end
`ifdef DIV_ARB_TIMEOUT_EN
            else if (wdog_q == CW'(TIMEOUT_CYCLES - 1)) begin
               quo_d   = '1;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               wdog_d  = wdog_q + CW'(1);
            end
`endif
         end
         RESP: begin
            if (bus.rsp_ready[owner_q]) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         last_q  <= GW'(NUM_REQ - 1);
         owner_q <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         quo_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         quo_q   <= quo_d;
      end
   end

`ifdef DIV_ARB_TIMEOUT_EN
   // Watchdog counter and sticky error flag.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wdog_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wdog_q <= wdog_d;
         err_q  <= err_d;
      end
   end
   assign bus.err_timeout = err_q;
`else
   assign bus.err_timeout = 1'b0;
`endif

   // req_ready is a same-cycle accept strobe; held low while reset is asserted.
   assign bus.req_ready    = (accept && reset) ? (NUM_REQ'(1) << grant_idx) : '0;
   assign bus.rsp_valid    = (state_q == RESP) ? (NUM_REQ'(1) << owner_q) : '0;
   assign bus.rsp_quotient = quo_q;
   assign bus.div_valid_in = (state_q == ISSUE);
   assign bus.div_dividend = dvd_q;
   assign bus.div_divisor  = dvs_q;
endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed self-checking bench for div_share_arbiter (NUM_REQ=2, 16/8-bit operands).
// The divider is emulated by driving div_valid_out/div_quotient at fixed latencies.
module tb_div_share_arbiter;
   logic clock;
   logic reset;

   int n_cmp = 0;
   int n_err = 0;

   div_share_arbiter_if #(.NUM_REQ(2), .DIVIDEND_WIDTH(16), .DIVISOR_WIDTH(8)) bus ();

   div_share_arbiter #(
      .NUM_REQ(2), .DIVIDEND_WIDTH(16), .DIVISOR_WIDTH(8), .TIMEOUT_CYCLES(64)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic cyc();
      @(posedge clock);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called in the accept cycle t0; returns settled in cycle t0+2+lat.
   task automatic run_div(input string tag, input int lat, input logic [15:0] q,
                          input logic [15:0] dvd, input logic [7:0] dvs);
      cyc();
      settle();
      check({tag, "_div_valid_in"}, 32'(bus.div_valid_in), 32'h1);
      check({tag, "_div_dividend"}, 32'(bus.div_dividend), 32'(dvd));
      check({tag, "_div_divisor"},  32'(bus.div_divisor),  32'(dvs));
      repeat (lat - 1) begin
         cyc();
         settle();
         check({tag, "_wait_quiet"}, {30'd0, bus.div_valid_in, |bus.rsp_valid}, 32'h0);
      end
      cyc();
      bus.div_valid_out = 1'b1;
      bus.div_quotient  = q;
      settle();
      check({tag, "_no_early_rsp"}, 32'(bus.rsp_valid), 32'h0);
      cyc();
      bus.div_valid_out = 1'b0;
      bus.div_quotient  = 16'hDEAD;
      settle();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish, expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] exp_g;

      reset             = 1'b0;
      bus.req_valid     = 2'b01;
      bus.req_dividend  = '0;
      bus.req_divisor   = '0;
      bus.rsp_ready     = '0;
      bus.div_valid_out = 1'b0;
      bus.div_quotient  = '0;

      // Reset state: all outputs low even with a request pending.
      cyc();
      cyc();
      settle();
      check("rst_req_ready",    32'(bus.req_ready),    32'h0);
      check("rst_rsp_valid",    32'(bus.rsp_valid),    32'h0);
      check("rst_div_valid_in", 32'(bus.div_valid_in), 32'h0);
      check("rst_rsp_quotient", 32'(bus.rsp_quotient), 32'h0);
      check("rst_err_timeout",  32'(bus.err_timeout),  32'h0);
      bus.req_valid = 2'b00;
      reset = 1'b1;
      cyc();

      // Single request 600/40 with divider latency 17.
      bus.req_valid    = 2'b01;
      bus.req_dividend = {16'd0, 16'd600};
      bus.req_divisor  = {8'd0, 8'd40};
      settle();
      check("t1_req_ready", 32'(bus.req_ready), 32'h1);
      run_div("t1", 17, 16'd15, 16'd600, 8'd40);
      check("t1_rsp_valid",    32'(bus.rsp_valid),    32'h1);
      check("t1_rsp_quotient", 32'(bus.rsp_quotient), 32'd15);
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b01;
      cyc();
      bus.rsp_ready = 2'b00;
      settle();
      check("t1_back_idle", 32'(bus.rsp_valid), 32'h0);

      // Fresh reset, then both requesters continuously valid: grants 0,1,0,1.
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      cyc();
      bus.req_valid    = 2'b11;
      bus.req_dividend = {16'd255, 16'd100};
      bus.req_divisor  = {8'd5, 8'd3};
      for (int k = 0; k < 4; k++) begin
         settle();
         exp_g = (k % 2 == 0) ? 32'h1 : 32'h2;
         check("rr_grant", 32'(bus.req_ready), exp_g);
         if (k % 2 == 0) run_div("rr0", 3, 16'd33, 16'd100, 8'd3);
         else            run_div("rr1", 3, 16'd51, 16'd255, 8'd5);
         check("rr_rsp_valid",    32'(bus.rsp_valid),    exp_g);
         check("rr_rsp_quotient", 32'(bus.rsp_quotient), (k % 2 == 0) ? 32'd33 : 32'd51);
         bus.rsp_ready = exp_g[1:0];
         if (k == 3) bus.req_valid = 2'b00;
         cyc();
         bus.rsp_ready = 2'b00;
      end

      // Divide by zero from requester 1: answered next cycle, divider untouched.
      bus.req_valid    = 2'b10;
      bus.req_dividend = {16'h1234, 16'd0};
      bus.req_divisor  = {8'd0, 8'd0};
      settle();
      check("dz_req_ready",    32'(bus.req_ready),    32'h2);
      check("dz_div_idle_t0",  32'(bus.div_valid_in), 32'h0);
      cyc();
      bus.req_valid = 2'b00;
      settle();
      check("dz_rsp_valid",    32'(bus.rsp_valid),    32'h2);
      check("dz_rsp_quotient", 32'(bus.rsp_quotient), 32'hFFFF);
      check("dz_div_idle_t1",  32'(bus.div_valid_in), 32'h0);
      bus.rsp_ready = 2'b10;
      cyc();
      bus.rsp_ready = 2'b00;
      settle();
      check("dz_done_rsp",     32'(bus.rsp_valid),    32'h0);
      check("dz_div_idle_t2",  32'(bus.div_valid_in), 32'h0);

      // Back-pressure: owner 0 stalls 10 cycles while requester 1 waits.
      bus.req_valid    = 2'b11;
      bus.req_dividend = {16'd90, 16'd200};
      bus.req_divisor  = {8'd9, 8'd7};
      settle();
      check("bp_req_ready", 32'(bus.req_ready), 32'h1);
      run_div("bp", 2, 16'd28, 16'd200, 8'd7);
      bus.rsp_ready = 2'b10;
      for (int i = 0; i < 10; i++) begin
         settle();
         check("bp_hold_valid",    32'(bus.rsp_valid),    32'h1);
         check("bp_hold_quotient", 32'(bus.rsp_quotient), 32'd28);
         check("bp_hold_no_grant", 32'(bus.req_ready),    32'h0);
         cyc();
      end
      bus.rsp_ready = 2'b01;
      bus.req_valid = 2'b10;
      settle();
      check("bp_hs_no_grant", 32'(bus.req_ready), 32'h0);
      cyc();
      bus.rsp_ready = 2'b00;
      settle();
      check("bp_next_grant", 32'(bus.req_ready), 32'h2);
      check("bp_rsp_clear",  32'(bus.rsp_valid), 32'h0);

      // Reset during WAIT abandons the transaction; late divider result ignored.
      cyc();
      bus.req_valid = 2'b00;
      settle();
      check("rw_issue",    32'(bus.div_valid_in), 32'h1);
      check("rw_dividend", 32'(bus.div_dividend), 32'd90);
      cyc();
      reset = 1'b0;
      bus.req_valid = 2'b01;
      settle();
      check("rw_rst_req_ready",    32'(bus.req_ready),    32'h0);
      check("rw_rst_rsp_valid",    32'(bus.rsp_valid),    32'h0);
      check("rw_rst_div_valid_in", 32'(bus.div_valid_in), 32'h0);
      check("rw_rst_div_dividend", 32'(bus.div_dividend), 32'h0);
      check("rw_rst_div_divisor",  32'(bus.div_divisor),  32'h0);
      check("rw_rst_rsp_quotient", 32'(bus.rsp_quotient), 32'h0);
      cyc();
      reset = 1'b1;
      bus.req_valid     = 2'b00;
      bus.div_valid_out = 1'b1;
      bus.div_quotient  = 16'hAAAA;
      settle();
      check("rw_late_rsp0", 32'(bus.rsp_valid), 32'h0);
      cyc();
      bus.div_valid_out = 1'b0;
      settle();
      check("rw_late_rsp1", 32'(bus.rsp_valid),    32'h0);
      check("rw_late_quo",  32'(bus.rsp_quotient), 32'h0);
      cyc();
      bus.req_valid    = 2'b11;
      bus.req_dividend = {16'd255, 16'd100};
      bus.req_divisor  = {8'd5, 8'd3};
      settle();
      check("rw_first_grant", 32'(bus.req_ready), 32'h1);
      run_div("rw", 4, 16'd33, 16'd100, 8'd3);
      check("rw_rsp_valid",    32'(bus.rsp_valid),    32'h1);
      check("rw_rsp_quotient", 32'(bus.rsp_quotient), 32'd33);
      bus.rsp_ready = 2'b01;
      bus.req_valid = 2'b00;
      cyc();
      bus.rsp_ready = 2'b00;

`ifdef DIV_ARB_TIMEOUT_EN
      // Divider never answers: watchdog responds at t0+66 and flags the error.
      bus.req_valid    = 2'b01;
      bus.req_dividend = {16'd0, 16'd1000};
      bus.req_divisor  = {8'd0, 8'd10};
      settle();
      check("to_req_ready", 32'(bus.req_ready), 32'h1);
      cyc();
      bus.req_valid = 2'b00;
      settle();
      check("to_issue", 32'(bus.div_valid_in), 32'h1);
      repeat (64) cyc();
      settle();
      check("to_not_yet_rsp", 32'(bus.rsp_valid),   32'h0);
      check("to_not_yet_err", 32'(bus.err_timeout), 32'h0);
      cyc();
      settle();
      check("to_rsp_valid",    32'(bus.rsp_valid),    32'h1);
      check("to_rsp_quotient", 32'(bus.rsp_quotient), 32'hFFFF);
      check("to_err_set",      32'(bus.err_timeout),  32'h1);
      bus.rsp_ready = 2'b01;
      cyc();
      bus.rsp_ready    = 2'b00;
      bus.req_valid    = 2'b10;
      bus.req_dividend = {16'd100, 16'd0};
      bus.req_divisor  = {8'd3, 8'd0};
      settle();
      check("to_next_grant", 32'(bus.req_ready), 32'h2);
      run_div("to2", 3, 16'd33, 16'd100, 8'd3);
      check("to2_rsp_valid",    32'(bus.rsp_valid),    32'h2);
      check("to2_rsp_quotient", 32'(bus.rsp_quotient), 32'd33);
      check("to2_err_sticky",   32'(bus.err_timeout),  32'h1);
      bus.rsp_ready = 2'b10;
      bus.req_valid = 2'b00;
      cyc();
      bus.rsp_ready = 2'b00;
`else
      settle();
      check("err_timeout_tied", 32'(bus.err_timeout), 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/div_share_arbiter.md
Name: div_share_arbiter

Overview:
Round-robin arbiter that shares one iterative unsigned divider (div_unsigned, valid_in/valid_out style) between NUM_REQ pixel-pipeline stages, e.g. gaussian_blur normalisation and sobel/NMS magnitude scaling. It accepts one division at a time, sequences the divider handshake, and returns the quotient to the owning requester. Divide-by-zero requests are resolved locally without using the divider.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
DIVIDEND_WIDTH, 16, dividend and quotient width
DIVISOR_WIDTH, 8, divisor width
TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only with DIV_ARB_TIMEOUT_EN

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
req_valid  in  NUM_REQ  per-requester division request
req_ready  out  NUM_REQ  one-hot; high for the single cycle a request is accepted
req_dividend  in  NUM_REQ*DIVIDEND_WIDTH  packed; slice i belongs to requester i
req_divisor  in  NUM_REQ*DIVISOR_WIDTH  packed; slice i belongs to requester i
rsp_valid  out  NUM_REQ  one-hot; result available for requester i
rsp_ready  in  NUM_REQ  requester i consumes the result
rsp_quotient  out  DIVIDEND_WIDTH  shared result bus; meaningful only while any rsp_valid is high
div_valid_in  out  1  start pulse to the divider
div_dividend  out  DIVIDEND_WIDTH  operand to the divider, held from ISSUE until the next accept
div_divisor  out  DIVISOR_WIDTH  operand to the divider, held from ISSUE until the next accept
div_valid_out  in  1  divider result valid
div_quotient  in  DIVIDEND_WIDTH  divider result
err_timeout  out  1  sticky watchdog flag; constant 0 without DIV_ARB_TIMEOUT_EN

Behaviour:
- Reset (asynchronous, while reset is 0): state=IDLE; last_grant=NUM_REQ-1, so requester 0 wins first; owner, operand, quotient and watchdog registers cleared to 0. All outputs are 0.
- Reset mid-operation abandons the transaction: no response is issued, and a late div_valid_out after release is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from last_grant+1 upward, modulo NUM_REQ.
  - Assert req_ready[grant] combinationally in the same cycle, latch dividend, divisor and owner, then set last_grant=grant.
  - If the latched divisor is 0, go to RESP with quotient = all ones (saturate) and do not touch the divider.
  - Otherwise go to ISSUE.
- ISSUE: div_valid_in=1 for exactly one cycle, with div_dividend/div_divisor driven from the latched registers. Go to WAIT.
- WAIT: on div_valid_out=1, latch div_quotient and go to RESP. div_valid_out in any other state is ignored.
- RESP:
  - rsp_valid[owner]=1 and rsp_quotient=latched value, both held stable until rsp_ready[owner]=1.
  - On that cycle go to IDLE. The next grant is evaluated in IDLE, so back-to-back accepts are at least 1 cycle apart.
  - rsp_ready on non-owner bits is ignored.
- Latency with divider latency L (div_valid_in to div_valid_out):
  - accept at t0, div_valid_in at t0+1, div_valid_out at t0+1+L, rsp_valid at t0+2+L.
  - Divide-by-zero: rsp_valid at t0+1.
- Fairness: each requester is granted at most once while any other requester is continuously requesting. Requesters must hold req_valid and operands stable until req_ready.
- No reordering: exactly one transaction is outstanding, and the owner stays constant from accept until response handshake.
- Back-pressure: a stalled rsp_ready blocks all new grants (no bypass).

Optional Feature:
DIV_ARB_TIMEOUT_EN
- Defined:
  - A cycle counter runs in WAIT and clears on entry to WAIT.
  - If it reaches TIMEOUT_CYCLES without div_valid_out, go to RESP with quotient = all ones and set err_timeout.
  - err_timeout stays set until reset.
- Undefined: no counter, WAIT waits indefinitely, and err_timeout is tied to 0.

Test Plan:
- Requester 0 only, dividend 600, divisor 40, divider L=17 -> req_ready[0] on the accept cycle; div_valid_in 1 cycle later with 600/40; rsp_valid[0] with quotient 15 at t0+19; rsp_ready=1 returns the arbiter to IDLE.
- Both requesters valid continuously after reset, operands 100/3 and 255/5 -> grant order 0,1,0,1; quotients 33 and 51; never two grants to the same requester in a row.
- Requester 1, dividend 0x1234, divisor 0 -> rsp_valid[1] at t0+1 with quotient 0xFFFF; div_valid_in never asserted.
- Hold rsp_ready[0]=0 for 10 cycles while requester 1 is valid -> rsp_valid[0] and rsp_quotient stay stable; req_ready[1] stays 0 until the cycle after the handshake.
- Drive reset=0 during WAIT, then release; inject div_valid_out afterwards -> all outputs 0 during reset; no rsp_valid; the first grant after release goes to requester 0.
- With DIV_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64, divider never responds -> rsp_valid[owner] with quotient 0xFFFF at t0+66; err_timeout=1 and stays 1 through later transactions.
